// File: rtl/demod_frame_avg.sv
// demod_frame_avg: averages 2^AVG_LOG2 demod results per electrode-pair
// measurement after discarding SKIP settling results, and hands each
// average with its index to the frame buffer over a valid/ready port.
//
// Ports:
//   Clk, Rst            clock, synchronous active-high reset
//   Start               one-cycle frame start, honoured only when idle
//   DemodRdy            one-cycle strobe, DemodRslt/Otr valid
//   DemodRslt, Otr      signed 32-bit demod result, ADC over-range flag
//   MeasIdx             current measurement index (drives switching)
//   OutVld/OutRdy       valid/ready handshake towards the frame buffer
//   OutDat/OutIdx/OutOvr averaged result, its index, over-range seen
//   FrameDone           one-cycle pulse after the last transfer
//   Busy                high whenever not idle
//   DropErr             sticky, a result arrived while waiting in OUT
module demod_frame_avg #(
    parameter int AVG_LOG2 = 2,
    parameter int SKIP     = 1,
    parameter int NMEAS    = 66
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Start,
    input  logic        DemodRdy,
    input  logic [31:0] DemodRslt,
    input  logic        Otr,
    output logic [6:0]  MeasIdx,
    output logic        OutVld,
    input  logic        OutRdy,
    output logic [31:0] OutDat,
    output logic [6:0]  OutIdx,
    output logic        OutOvr,
    output logic        FrameDone,
    output logic        Busy,
    output logic        DropErr
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SKIP,
        S_ACC,
        S_OUT
    } state_t;

    localparam logic [6:0] AVG_LAST  = 7'((1 << AVG_LOG2) - 1);
    localparam logic [3:0] SKIP_LAST = 4'((SKIP > 0) ? SKIP - 1 : 0);
    localparam logic [6:0] IDX_LAST  = 7'(NMEAS - 1);
    // With no settling results to drop, a new index goes straight to ACC.
    localparam state_t     FIRST     = (SKIP == 0) ? S_ACC : S_SKIP;

    state_t             state;
    state_t             nxt;
    logic [3:0]         skip_cnt;
    logic [6:0]         smp_cnt;
    logic signed [39:0] acc;
    logic signed [39:0] sum;
    logic               ovr;
    logic               xfer;
    logic               last_smp;
    logic               last_idx;

    assign sum      = acc + $signed({{8{DemodRslt[31]}}, DemodRslt});
    assign xfer     = (state == S_OUT) && OutRdy;
    assign last_smp = (state == S_ACC) && DemodRdy
                      && (smp_cnt == AVG_LAST);
    assign last_idx = (MeasIdx == IDX_LAST);
    assign OutVld   = (state == S_OUT);
    assign Busy     = (state != S_IDLE);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= S_IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt = state;
        unique case (state)
            S_IDLE: if (Start) nxt = FIRST;
            S_SKIP: begin
                if (DemodRdy && (skip_cnt == SKIP_LAST)) nxt = S_ACC;
            end
            S_ACC:  if (last_smp) nxt = S_OUT;
            S_OUT: begin
                if (xfer) nxt = last_idx ? S_IDLE : FIRST;
            end
            default: nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            MeasIdx   <= '0;
            skip_cnt  <= '0;
            smp_cnt   <= '0;
            acc       <= '0;
            ovr       <= 1'b0;
            OutDat    <= '0;
            OutIdx    <= '0;
            OutOvr    <= 1'b0;
            FrameDone <= 1'b0;
            DropErr   <= 1'b0;
        end else begin
            FrameDone <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (Start) begin
                        MeasIdx  <= '0;
                        skip_cnt <= '0;
                        smp_cnt  <= '0;
                        acc      <= '0;
                        ovr      <= 1'b0;
                        DropErr  <= 1'b0;
                    end
                end
                S_SKIP: begin
                    if (DemodRdy) skip_cnt <= skip_cnt + 4'd1;
                end
                S_ACC: begin
                    if (DemodRdy) begin
                        acc     <= sum;
                        smp_cnt <= smp_cnt + 7'd1;
                        ovr     <= ovr | Otr;
                    end
                    if (last_smp) begin
                        // Arithmetic shift gives floor rounding.
                        OutDat <= 32'(sum >>> AVG_LOG2);
                        OutIdx <= MeasIdx;
                        OutOvr <= ovr | Otr;
                    end
                end
                S_OUT: begin
                    if (DemodRdy) DropErr <= 1'b1;
                    if (xfer) begin
                        skip_cnt <= '0;
                        smp_cnt  <= '0;
                        acc      <= '0;
                        ovr      <= 1'b0;
                        if (last_idx) begin
                            MeasIdx   <= '0;
                            FrameDone <= 1'b1;
                        end else begin
                            MeasIdx <= MeasIdx + 7'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_demod_frame_avg.sv
// tb_demod_frame_avg: directed self-checking bench for demod_frame_avg
// at default parameters (AVG_LOG2=2, SKIP=1, NMEAS=66).
module tb_demod_frame_avg;

    logic        Clk;
    logic        Rst;
    logic        Start;
    logic        DemodRdy;
    logic [31:0] DemodRslt;
    logic        Otr;
    logic [6:0]  MeasIdx;
    logic        OutVld;
    logic        OutRdy;
    logic [31:0] OutDat;
    logic [6:0]  OutIdx;
    logic        OutOvr;
    logic        FrameDone;
    logic        Busy;
    logic        DropErr;

    int nchk;
    int nerr;

    logic [31:0] smp [5];

    demod_frame_avg dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .Start    (Start),
        .DemodRdy (DemodRdy),
        .DemodRslt(DemodRslt),
        .Otr      (Otr),
        .MeasIdx  (MeasIdx),
        .OutVld   (OutVld),
        .OutRdy   (OutRdy),
        .OutDat   (OutDat),
        .OutIdx   (OutIdx),
        .OutOvr   (OutOvr),
        .FrameDone(FrameDone),
        .Busy     (Busy),
        .DropErr  (DropErr)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic send(input logic [31:0] v, input logic o);
        DemodRslt = v;
        Otr       = o;
        DemodRdy  = 1'b1;
        tick();
        DemodRdy  = 1'b0;
        Otr       = 1'b0;
    endtask

    // One measurement: smp[0] is the settling result, smp[1..4] averaged.
    task automatic meas(input int idx, input logic [4:0] om,
                        input logic [31:0] ed, input logic eo,
                        input logic last);
        for (int i = 0; i < 5; i++) send(smp[i], om[i]);
        chk("vld", {31'd0, OutVld}, 32'd1);
        chk("dat", OutDat, ed);
        chk("idx", {25'd0, OutIdx}, 32'(idx));
        chk("ovr", {31'd0, OutOvr}, {31'd0, eo});
        if (OutRdy) begin
            tick();
            chk("vld_off", {31'd0, OutVld}, 32'd0);
            chk("midx", {25'd0, MeasIdx}, last ? 32'd0 : 32'(idx + 1));
            chk("fdone", {31'd0, FrameDone}, {31'd0, last});
        end
    endtask

    task automatic pulse_start();
        Start = 1'b1;
        tick();
        Start = 1'b0;
    endtask

    initial begin
        nchk = 0;
        nerr = 0;
        Clk = 1'b0;
        Rst = 1'b1;
        Start = 1'b0;
        DemodRdy = 1'b0;
        DemodRslt = '0;
        Otr = 1'b0;
        OutRdy = 1'b1;
        repeat (3) tick();
        chk("rst_busy", {31'd0, Busy}, 32'd0);
        chk("rst_vld", {31'd0, OutVld}, 32'd0);
        chk("rst_midx", {25'd0, MeasIdx}, 32'd0);
        chk("rst_dat", OutDat, 32'd0);
        Rst = 1'b0;

        // Full frame, 100 skipped then 4,8,12,16 -> 10.
        pulse_start();
        chk("busy", {31'd0, Busy}, 32'd1);
        smp = '{32'd100, 32'd4, 32'd8, 32'd12, 32'd16};
        for (int i = 0; i < 66; i++)
            meas(i, 5'b0, 32'd10, 1'b0, i == 65);
        chk("idle_busy", {31'd0, Busy}, 32'd0);
        tick();
        chk("fdone_1cyc", {31'd0, FrameDone}, 32'd0);
        chk("idle_busy2", {31'd0, Busy}, 32'd0);

        // Frame 2: result arriving with Start is ignored.
        Start = 1'b1;
        DemodRslt = 32'd1000;
        DemodRdy = 1'b1;
        tick();
        Start = 1'b0;
        DemodRdy = 1'b0;
        chk("busy2", {31'd0, Busy}, 32'd1);
        chk("midx0", {25'd0, MeasIdx}, 32'd0);
        smp = '{32'd50, -32'sd1, -32'sd1, -32'sd1, -32'sd2};
        meas(0, 5'b0, 32'hFFFFFFFE, 1'b0, 1'b0);
        smp = '{32'd0, 32'h7FFFFFFF, 32'h7FFFFFFF,
                32'h7FFFFFFF, 32'h7FFFFFFF};
        meas(1, 5'b0, 32'h7FFFFFFF, 1'b0, 1'b0);
        smp = '{32'd0, 32'h80000000, 32'h80000000,
                32'h80000000, 32'h80000000};
        meas(2, 5'b0, 32'h80000000, 1'b0, 1'b0);
        smp = '{32'd9, 32'd1, 32'd2, 32'd3, 32'd4};
        meas(3, 5'b00001, 32'd2, 1'b0, 1'b0);
        smp = '{32'd0, 32'd4, 32'd4, 32'd4, 32'd4};
        meas(4, 5'b01000, 32'd4, 1'b1, 1'b0);

        // Backpressure with dropped results.
        OutRdy = 1'b0;
        smp = '{32'd0, 32'd8, 32'd8, 32'd8, 32'd8};
        meas(5, 5'b0, 32'd8, 1'b0, 1'b0);
        for (int c = 0; c < 20; c++) begin
            if (c == 3 || c == 9 || c == 15) begin
                DemodRslt = 32'h1234;
                Otr = 1'b1;
                DemodRdy = 1'b1;
            end
            tick();
            DemodRdy = 1'b0;
            Otr = 1'b0;
            chk("bp_vld", {31'd0, OutVld}, 32'd1);
            chk("bp_dat", OutDat, 32'd8);
            chk("bp_midx", {25'd0, MeasIdx}, 32'd5);
        end
        chk("bp_ovr", {31'd0, OutOvr}, 32'd0);
        chk("drop", {31'd0, DropErr}, 32'd1);
        OutRdy = 1'b1;
        tick();
        chk("bp_xfer", {31'd0, OutVld}, 32'd0);
        chk("bp_midx6", {25'd0, MeasIdx}, 32'd6);

        // Start while busy is ignored; DropErr stays.
        pulse_start();
        chk("sb_midx", {25'd0, MeasIdx}, 32'd6);
        chk("sb_drop", {31'd0, DropErr}, 32'd1);
        chk("sb_busy", {31'd0, Busy}, 32'd1);

        for (int i = 6; i < 31; i++) begin
            if (i == 30) OutRdy = 1'b0;
            smp = '{32'd77, 32'(i), 32'(i), 32'(i), 32'(i)};
            meas(i, 5'b0, 32'(i), 1'b0, 1'b0);
        end

        // Reset mid-frame, with Start asserted too.
        Rst = 1'b1;
        Start = 1'b1;
        tick();
        Rst = 1'b0;
        Start = 1'b0;
        chk("r_busy", {31'd0, Busy}, 32'd0);
        chk("r_vld", {31'd0, OutVld}, 32'd0);
        chk("r_midx", {25'd0, MeasIdx}, 32'd0);
        chk("r_dat", OutDat, 32'd0);
        chk("r_idx", {25'd0, OutIdx}, 32'd0);
        chk("r_ovr", {31'd0, OutOvr}, 32'd0);
        chk("r_fd", {31'd0, FrameDone}, 32'd0);
        chk("r_drop", {31'd0, DropErr}, 32'd0);
        tick();
        chk("r_fd2", {31'd0, FrameDone}, 32'd0);
        chk("r_idle", {31'd0, Busy}, 32'd0);

        pulse_start();
        OutRdy = 1'b1;
        chk("rs_busy", {31'd0, Busy}, 32'd1);
        chk("rs_midx", {25'd0, MeasIdx}, 32'd0);
        smp = '{32'd100, 32'd4, 32'd8, 32'd12, 32'd16};
        meas(0, 5'b0, 32'd10, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors",
                 nchk, nerr);
        $finish;
    end

endmodule
